unlock_seq_driver: RTL

Transmit-side companion to the 13-state input-sequence recognizer. On a start request it drives the 12-step unlock pattern onto the four recognizer inputs (i1..i4), holding each vector for a programmable number of cycles. It publishes the state code that a conforming recognizer must reach after each step, and can corrupt one chosen step for negative testing. It sits in front of the recognizer in the unlock datapath and in its bench harness.

---
 rtl/unlock_seq_driver.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/unlock_seq_driver.sv
// rtl/unlock_seq_driver.sv - drives the 12-step unlock pattern onto recognizer inputs
//
// Purpose: on start, plays the 12-entry unlock vector table onto drv and holds
// each vector for hold_cycles+1 cycles. It publishes the recognizer state code
// expected after each step. One step can optionally be inverted for negative
// testing.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   start        in   begin a sequence (sampled in IDLE only)
//   abort        in   drop an active sequence immediately
//   hold_cycles  in   extra hold cycles per step (latched at start)
//   fault_en     in   enable single-step corruption (latched at start)
//   fault_step   in   step 1..12 to corrupt; 0 or >12 disables (latched at start)
//   drv          out  recognizer inputs, drv[0]=i1 .. drv[3]=i4
//   step         out  current step 1..12, 0 when not sending
//   exp_code     out  expected fault-free recognizer code after this step
//   fault_active out  corrupted vector is on drv
//   busy         out  sequence in progress
//   done         out  one-cycle pulse on normal completion
module unlock_seq_driver #(
    parameter int         HOLD_W   = 8,
    parameter logic [3:0] IDLE_VEC = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              fault_en,
    input  logic [3:0]        fault_step,
    output logic [3:0]        drv,
    output logic [3:0]        step,
    output logic [16:0]       exp_code,
    output logic              fault_active,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_STEP  = 4'd12;
    localparam logic [16:0] FINAL_CODE = 17'd4100;

    state_t            state_q;
    logic [3:0]        drv_q;
    logic [3:0]        step_q;
    logic [16:0]       exp_code_q;
    logic              fault_active_q;
    logic              busy_q;
    logic              done_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              fault_en_q;
    logic [3:0]        fault_step_q;

    logic [3:0]        step_d;
    logic              fault_d;
    logic              start_fault_d;

    function automatic logic [3:0] vec_of(input logic [3:0] s);
        logic [3:0] v;
        case (s)
            4'd1:    v = 4'h4;
            4'd2:    v = 4'h9;
            4'd3:    v = 4'h0;
            4'd4:    v = 4'h4;
            4'd5:    v = 4'h2;
            4'd6:    v = 4'h1;
            4'd7:    v = 4'h8;
            4'd8:    v = 4'h0;
            4'd9:    v = 4'h8;
            4'd10:   v = 4'h4;
            4'd11:   v = 4'h1;
            4'd12:   v = 4'h0;
            default: v = IDLE_VEC;
        endcase
        return v;
    endfunction

    function automatic logic [16:0] code_of(input logic [3:0] s);
        logic [16:0] c;
        case (s)
            4'd1:    c = 17'd200;
            4'd2:    c = 17'd700;
            4'd3:    c = 17'd900;
            4'd4:    c = 17'd1300;
            4'd5:    c = 17'd1800;
            4'd6:    c = 17'd2300;
            4'd7:    c = 17'd2800;
            4'd8:    c = 17'd3100;
            4'd9:    c = 17'd3400;
            4'd10:   c = 17'd3600;
            4'd11:   c = 17'd3800;
            4'd12:   c = 17'd4100;
            default: c = 17'd0;
        endcase
        return c;
    endfunction

    // Outputs are registered, so the values for the step being entered are
    // computed one cycle ahead: step_d is the step that follows step_q.
    // A fault_step of 0 or >12 never matches a live step and so never fires.
    always_comb begin
        step_d        = step_q + 4'd1;
        fault_d       = fault_en_q && (fault_step_q == step_d);
        start_fault_d = fault_en && (fault_step == 4'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            drv_q          <= IDLE_VEC;
            step_q         <= 4'd0;
            exp_code_q     <= 17'd0;
            fault_active_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cnt_q          <= '0;
            hold_q         <= '0;
            fault_en_q     <= 1'b0;
            fault_step_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q        <= ST_SEND;
                        hold_q         <= hold_cycles;
                        fault_en_q     <= fault_en;
                        fault_step_q   <= fault_step;
                        cnt_q          <= '0;
                        step_q         <= 4'd1;
                        drv_q          <= start_fault_d ? ~vec_of(4'd1) : vec_of(4'd1);
                        fault_active_q <= start_fault_d;
                        exp_code_q     <= code_of(4'd1);
                        busy_q         <= 1'b1;
                    end
                end

                ST_SEND: begin
                    if (abort) begin
                        // Abort wins over hold expiry; the sequence is simply dropped.
                        state_q        <= ST_IDLE;
                        drv_q          <= IDLE_VEC;
                        step_q         <= 4'd0;
                        exp_code_q     <= 17'd0;
                        fault_active_q <= 1'b0;
                        busy_q         <= 1'b0;
                        cnt_q          <= '0;
                    end else if (cnt_q == hold_q) begin
                        cnt_q <= '0;
                        if (step_q == LAST_STEP) begin
                            state_q        <= ST_DONE;
                            drv_q          <= IDLE_VEC;
                            step_q         <= 4'd0;
                            exp_code_q     <= FINAL_CODE;
                            fault_active_q <= 1'b0;
                            busy_q         <= 1'b0;
                            done_q         <= 1'b1;
                        end else begin
                            step_q         <= step_d;
                            drv_q          <= fault_d ? ~vec_of(step_d) : vec_of(step_d);
                            fault_active_q <= fault_d;
                            exp_code_q     <= code_of(step_d);
                        end
                    end else begin
                        // Compare happens before increment, so the counter never wraps
                        // even with hold_cycles at its maximum.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    // Single-cycle completion; start is deliberately not sampled here.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q        <= ST_IDLE;
                    drv_q          <= IDLE_VEC;
                    step_q         <= 4'd0;
                    exp_code_q     <= 17'd0;
                    fault_active_q <= 1'b0;
                    busy_q         <= 1'b0;
                    done_q         <= 1'b0;
                    cnt_q          <= '0;
                end
            endcase
        end
    end

    assign drv          = drv_q;
    assign step         = step_q;
    assign exp_code     = exp_code_q;
    assign fault_active = fault_active_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
